stream_arb_mux: RTL and testbench
=================================

# stream_arb_mux

Parametrised N-channel, WIDTH-bit arbitrated multiplexer with a registered valid/ready output stage. It replaces the fixed two-input select where several producers compete for one consumer, for example writeback sources or memory-port requesters in the RISC-V core. It chooses one requesting channel per cycle, using either round-robin or fixed priority selected at run time. The selected beat is registered together with its source index.

## Interface
- WIDTH, 32, data width per channel
- N, 4, number of input channels (N >= 1)
- IDW, $clog2(N) (min 1), width of channel index
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- in_valid  input  N  per-channel request
- in_data  input  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_ready  output  N  per-channel accept; one-hot or zero
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered data
- out_id  output  IDW  index of the channel that supplied out_data
- out_ready  input  1  consumer accept

## Operation
- Output slot is free when out_valid==0 or out_ready==1 (pass-through on pop).
- Grant (combinational):
  - round-robin: first channel with in_valid set, searching from ptr upward, wrapping at N-1 -> 0
  - fixed: lowest-index channel with in_valid set
- in_ready[g] = 1 only for the granted channel g, and only when the slot is free; all other bits are 0.
- Transfer on in_valid[g] & in_ready[g]: load out_data, out_id=g, out_valid=1.
- Slot free with no valid input: out_valid goes to 0 if the beat was popped.
- ptr updates to (g+1) mod N only on a transfer in round-robin mode.
- ptr is unchanged in fixed mode and on cycles with no transfer.
- out_valid=1 & out_ready=0: out_data and out_id are held stable, in_ready is all zero, ptr is held.
- A mode change takes effect at the next grant evaluation. ptr is not cleared.
- N=1: grant is channel 0, ptr stays 0, out_id is always 0.
- Producers may drop in_valid without a transfer. The arbiter does not require valid to be held.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat per cycle while out_ready=1.
- Reset values: out_valid=0, out_data=0, out_id=0, ptr=0, lock state clear.
  - in_ready=0 during the reset cycle.
- Reset mid-operation: the held beat is discarded, with no pop required. The first post-reset transfer is possible in the cycle after rst_n rises.
- Simultaneous pop and push in one cycle: the new beat replaces the old one, and out_valid stays 1.

## Configuration
- STREAM_ARB_MUX_LOCK_EN defined:
  - adds input in_last[N] and output out_last
  - once channel g transfers a beat with in_last[g]==0, grant is locked to g, regardless of mode and other requests, until a beat with in_last[g]==1 transfers
  - ptr advances only on the transfer of the last beat
  - out_last is registered alongside out_data; its reset value is 0
  - reset clears the lock
- Not defined: those ports are absent, and arbitration is re-evaluated on every beat.

## Structure
- Package stream_arb_pkg holds:
  - the mode encoding constants (ARB_RR=1'b0, ARB_FIXED=1'b1)
  - a helper function computing IDW from N
- Sub-module rr_arbiter(N) is purely combinational. It takes req[N], ptr, mode, lock and locked_id, and returns a one-hot grant[N] plus the encoded grant_id.
- The top level contains the output register, ptr and the lock state.

## Test plan
- Round-robin fairness: N=4, WIDTH=32, mode=0, all in_valid=1, in_data[i]=32'hA0+i, out_ready=1 -> out_id sequence 0,1,2,3,0,… and out_data=32'hA0..A3, one beat per cycle.
- Fixed priority: mode=1, in_valid=4'b1010 held -> out_id=1 on every beat, channel 3 never granted, and ptr unchanged.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 and out_data=32'hDEAD_BEEF -> data and id stable, in_ready=0; out_ready=1 -> the next granted beat appears the following cycle.
- Pointer wrap and sparse requests: ptr=3 and only in_valid[1]=1 -> channel 1 granted, then ptr=2; with no requests the next cycle, ptr stays 2 and out_valid drops after the pop.
- Reset mid-stream: assert rst_n=0 while out_valid=1 -> the next edge gives out_valid=0, out_data=0, out_id=0, ptr=0.
- Lock (STREAM_ARB_MUX_LOCK_EN): channel 2 sends a 3-beat packet with in_last=0,0,1 while channel 0 is also requesting -> out_id=2,2,2, then 0, and out_last=1 only on the third beat.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared definitions for the stream arbitrated multiplexer:
// arbitration mode encoding and the channel-index width helper.
package stream_arb_pkg;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int calc_idw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: round-robin from ptr, fixed lowest-index
// priority, or a hard lock onto locked_id. Returns one-hot grant plus index.
module rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = calc_idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           mode,
  input  logic           lock,
  input  logic [IDW-1:0] locked_id,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic found;
  int   j;

  // Select the winning channel index; a lock overrides both modes.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    j        = 0;
    if (lock) begin
      if (req[locked_id]) begin
        found    = 1'b1;
        grant_id = locked_id;
      end
    end else if (mode == ARB_FIXED) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[IDW'(i)]) begin
          found    = 1'b1;
          grant_id = IDW'(i);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        j = int'(ptr) + i;
        if (j >= N) j = j - N;
        if (!found && req[IDW'(j)]) begin
          found    = 1'b1;
          grant_id = IDW'(j);
        end
      end
    end
  end

  // Expand the winning index to a one-hot grant (zero when nobody requests).
  always_comb begin
    grant = '0;
    if (found) grant[grant_id] = 1'b1;
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-channel arbitrated stream multiplexer with a registered valid/ready
// output slot carrying data and source index.
// Optional packet locking is enabled by defining STREAM_ARB_MUX_LOCK_EN,
// which adds in_last/out_last and holds the grant until a last beat.
//
// Handshake: a beat moves on a channel when in_valid[i] & in_ready[i] at a
// rising edge, and leaves the output slot when out_valid & out_ready. The
// slot accepts a new beat when empty or being popped in the same cycle.
module stream_arb_mux
  import stream_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int IDW   = calc_idw(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
`ifdef STREAM_ARB_MUX_LOCK_EN
  input  logic [N-1:0]       in_last,
`endif
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [IDW-1:0]     out_id,
  input  logic               out_ready,
`ifdef STREAM_ARB_MUX_LOCK_EN
  output logic               out_last,
`endif
  output logic [IDW-1:0]     dbg_ptr,
  output logic               dbg_locked
);

  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic           slot_free;
  logic           xfer;
  logic           is_last;

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .mode      (mode),
    .lock      (lock_q),
    .locked_id (lock_id_q),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  // Offer the grant only when the output slot can take a beat and not in reset.
  always_comb begin
    slot_free = !out_valid || out_ready;
    in_ready  = (rst_n && slot_free) ? grant : '0;
    xfer      = |in_ready;
  end

  // Whether the beat being granted closes its packet.
  always_comb begin
`ifdef STREAM_ARB_MUX_LOCK_EN
    is_last = in_last[grant_id];
`else
    is_last = 1'b1;
`endif
  end

  // Round-robin pointer moves past the winner only when a packet completes.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && (mode == ARB_RR) && is_last) begin
      ptr_d = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Lock next-state: engage on a non-last beat, release on the last one.
  always_comb begin
`ifdef STREAM_ARB_MUX_LOCK_EN
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (xfer) begin
      lock_d    = !is_last;
      lock_id_d = grant_id;
    end
`else
    lock_d    = 1'b0;
    lock_id_d = '0;
`endif
  end

  // Arbitration state registers: pointer and lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Output slot: load on transfer, empty on pop without refill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
`ifdef STREAM_ARB_MUX_LOCK_EN
      out_last  <= 1'b0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_id*WIDTH +: WIDTH];
      out_id    <= grant_id;
`ifdef STREAM_ARB_MUX_LOCK_EN
      out_last  <= is_last;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Expose arbitration state for observation.
  always_comb begin
    dbg_ptr    = ptr_q;
    dbg_locked = lock_q;
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: directed scenarios plus random traffic, checked
// by a queue-based scoreboard fed from a behavioural arbitration model.
module tb_stream_arb_mux;

  localparam int N     = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;
  localparam int EW    = 1 + IDW + WIDTH;
`ifdef STREAM_ARB_MUX_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic               mode;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic [N-1:0]       in_last_v;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [IDW-1:0]     out_id;
  logic               out_ready;
  logic [IDW-1:0]     dbg_ptr;
  logic               dbg_locked;
`ifdef STREAM_ARB_MUX_LOCK_EN
  logic               out_last;
`endif

  stream_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
`ifdef STREAM_ARB_MUX_LOCK_EN
    .in_last    (in_last_v),
`endif
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
`ifdef STREAM_ARB_MUX_LOCK_EN
    .out_last   (out_last),
`endif
    .dbg_ptr    (dbg_ptr),
    .dbg_locked (dbg_locked)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_last_v = '1;
    out_ready = 1'b0;
  end

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [WIDTH-1:0] chan_data[N];
  int   m_ptr   = 0;
  bit   m_occ   = 0;
  bit   m_lock  = 0;
  int   m_lid   = 0;
  bit   post_reset = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner by the arbitration rules: locked channel, else the requester with
  // the smallest distance (index in fixed mode, circular distance from ptr in RR).
  function automatic int pick(input logic [N-1:0] v, input int p, input logic m,
                              input bit lk, input int lid);
    int best;
    int bestd;
    int d;
    if (lk) return v[lid] ? lid : -1;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        d = m ? i : (i - p + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  // Driver: apply one cycle of inputs, check combinational/state outputs
  // against the model, and push the expected beat on a predicted transfer.
  task automatic step(input logic [N-1:0] v, input logic m, input logic r,
                      input logic [N-1:0] l, input bit rst);
    int g;
    bit free;
    bit lastb;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    rst_n     = !rst;
    in_valid  = v;
    mode      = m;
    out_ready = r;
    in_last_v = l;
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = chan_data[i];
    #1;
    if (rst) begin
      check("reset_in_ready", 64'(in_ready), 64'(0));
      m_ptr  = 0;
      m_occ  = 0;
      m_lock = 0;
      m_lid  = 0;
      exp_q.delete();
      post_reset = 1;
    end else begin
      if (post_reset) begin
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_id", 64'(out_id), 64'(0));
`ifdef STREAM_ARB_MUX_LOCK_EN
        check("rst_out_last", 64'(out_last), 64'(0));
`endif
        post_reset = 0;
      end
      check("out_valid", 64'(out_valid), 64'(m_occ));
      check("ptr", 64'(dbg_ptr), 64'(m_ptr));
      check("locked", 64'(dbg_locked), 64'(m_lock));
      free    = !m_occ || r;
      g       = pick(v, m_ptr, m, m_lock, m_lid);
      exp_rdy = '0;
      if (free && g >= 0) exp_rdy[g] = 1'b1;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (free && g >= 0) begin
        lastb = LOCK_EN ? l[g] : 1'b1;
        exp_q.push_back({lastb, IDW'(g), chan_data[g]});
        m_occ = 1;
        if (LOCK_EN) begin
          m_lock = !lastb;
          m_lid  = g;
        end
        if (!m && lastb) m_ptr = (g + 1) % N;
      end else if (r) begin
        m_occ = 0;
      end
    end
  endtask

  // Monitor: whenever a beat is presented, compare it with the queue head;
  // pop it when the consumer accepts.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got id %0d data %0h, expected no beat", out_id, out_data);
        end else begin
          e = exp_q[0];
          check("out_data", 64'(out_data), 64'(e[WIDTH-1:0]));
          check("out_id", 64'(out_id), 64'(e[WIDTH +: IDW]));
`ifdef STREAM_ARB_MUX_LOCK_EN
          check("out_last", 64'(out_last), 64'(e[EW-1]));
`endif
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Stimulus sequence
  initial begin
    logic [N-1:0] rv;
    logic [N-1:0] rl;
    logic         rm;
    logic         rr;
    for (int i = 0; i < N; i++) chan_data[i] = $urandom;

    // Reset
    step('0, 1'b0, 1'b0, '1, 1'b1);
    step('1, 1'b0, 1'b1, '1, 1'b1);

    // Round-robin fairness, all channels requesting
    for (int i = 0; i < N; i++) chan_data[i] = 32'hA0 + i;
    for (int c = 0; c < 9; c++) step(4'b1111, 1'b0, 1'b1, '1, 1'b0);

    // Fixed priority: channel 1 always beats channel 3
    for (int c = 0; c < 6; c++) step(4'b1010, 1'b1, 1'b1, '1, 1'b0);

    // Backpressure with a held beat
    chan_data[1] = 32'hDEAD_BEEF;
    step(4'b0010, 1'b1, 1'b1, '1, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b1111, 1'b1, 1'b0, '1, 1'b0);
    step(4'b1111, 1'b1, 1'b1, '1, 1'b0);
    step(4'b0000, 1'b1, 1'b1, '1, 1'b0);

    // Pointer wrap: move ptr to 3, then a lone request from channel 1
    step(4'b0100, 1'b0, 1'b1, '1, 1'b0);
    step(4'b0010, 1'b0, 1'b1, '1, 1'b0);
    step(4'b0000, 1'b0, 1'b1, '1, 1'b0);
    step(4'b0000, 1'b0, 1'b1, '1, 1'b0);

`ifdef STREAM_ARB_MUX_LOCK_EN
    // Packet lock: channel 2 sends three beats while channel 0 also requests
    step(4'b0010, 1'b0, 1'b1, '1, 1'b0);
    step(4'b0101, 1'b0, 1'b1, 4'b0000, 1'b0);
    step(4'b0101, 1'b0, 1'b1, 4'b0000, 1'b0);
    step(4'b0101, 1'b0, 1'b1, 4'b0100, 1'b0);
    step(4'b0101, 1'b0, 1'b1, '1, 1'b0);
    step(4'b0000, 1'b0, 1'b1, '1, 1'b0);
`endif

    // Reset while a beat is held
    step(4'b1111, 1'b0, 1'b0, '1, 1'b0);
    step(4'b1111, 1'b0, 1'b0, '1, 1'b0);
    step(4'b1111, 1'b0, 1'b0, '1, 1'b1);
    step(4'b1111, 1'b0, 1'b1, '1, 1'b0);

    // Random traffic with occasional mode flips and one mid-run reset
    rm = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) chan_data[i] = $urandom;
      rv = N'($urandom_range(0, (1 << N) - 1));
      rl = N'($urandom_range(0, (1 << N) - 1));
      rr = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) rm = ~rm;
      step(rv, rm, rr, rl, (c == 700));
    end

    // Drain and confirm every predicted beat was delivered
    for (int c = 0; c < 3; c++) step('0, 1'b0, 1'b1, '1, 1'b0);
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
